breakbeam_multi_debounce: RTL and testbench

BREAKBEAM_MULTI_DEBOUNCE -- requirements
Module: breakbeam_multi_debounce

---
 rtl/breakbeam_pkg.sv | 13 +
 rtl/breakbeam_chan.sv | 67 ++++++
 rtl/breakbeam_multi_debounce.sv | 86 ++++++++
 tb/tb_breakbeam_multi_debounce.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/breakbeam_pkg.sv
// Shared defaults for the break-beam debounce block.
package breakbeam_pkg;
    localparam int DEF_NUM_CH       = 2;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int MIN_SYNC_STAGES  = 2;
    localparam int DEF_CNT_WIDTH    = 12;
    localparam int DEF_PERIOD_WIDTH = 24;

    // Fewer than two flops would leave the first stage exposed to metastability.
    function automatic int clamp_sync(input int n);
        return (n < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : n;
    endfunction
endpackage

// File: rtl/breakbeam_chan.sv
// One channel: polarity fix, synchronizer, debounce counter, edge strobes.
// din_clean follows a raw change SYNC_STAGES+eff_limit edges later; no backpressure.
module breakbeam_chan
    import breakbeam_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter logic INVERT      = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din_raw_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 clean_o,
    output logic                 rise_o,
    output logic                 fall_o
);
    localparam int SYNC_N = clamp_sync(SYNC_STAGES);

    logic [SYNC_N-1:0]    sync_q, sync_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, eff_limit;
    logic                 clean_q, clean_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 synced;

    assign sync_d    = {sync_q[SYNC_N-2:0], din_raw_i ^ INVERT};
    assign synced    = sync_q[SYNC_N-1];
    assign eff_limit = (limit_i == '0) ? CNT_WIDTH'(1) : limit_i;

    // >= rather than == so a limit lowered mid-count accepts on the next differing cycle.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced != clean_q) begin
            if (cnt_q >= eff_limit - 1'b1) begin
                clean_d = synced;
                rise_d  = synced;
                fall_d  = ~synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/breakbeam_multi_debounce.sv
// Multi-channel break-beam debouncer with a rise-to-rise period meter on channel 0.
// Period result appears one cycle after the closing rise_pulse[0]; no backpressure.
module breakbeam_multi_debounce
    import breakbeam_pkg::*;
#(
    parameter int                NUM_CH       = DEF_NUM_CH,
    parameter int                SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int                CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter logic [NUM_CH-1:0] INVERT_MASK  = {NUM_CH{1'b0}},
    parameter int                PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       din_raw,
    input  logic [CNT_WIDTH-1:0]    debounce_limit,
    output logic [NUM_CH-1:0]       din_clean,
    output logic [NUM_CH-1:0]       rise_pulse,
    output logic [NUM_CH-1:0]       fall_pulse,
    output logic [PERIOD_WIDTH-1:0] period_cycles,
    output logic                    period_valid,
    output logic                    period_overflow
);
    localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        breakbeam_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_WIDTH  (CNT_WIDTH),
            .INVERT     (INVERT_MASK[i])
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .din_raw_i(din_raw[i]),
            .limit_i  (debounce_limit),
            .clean_o  (din_clean[i]),
            .rise_o   (rise_pulse[i]),
            .fall_o   (fall_pulse[i])
        );
    end

    logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d, per_cnt_inc;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    armed_q, armed_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;

    // Saturating +1 doubles as the min(counter+1, all-ones) load value.
    assign per_cnt_inc = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + 1'b1;

    always_comb begin
        per_cnt_d = per_cnt_inc;
        period_d  = period_q;
        armed_d   = armed_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        if (rise_pulse[0]) begin
            per_cnt_d = '0;
            armed_d   = 1'b1;
            if (armed_q) begin
                period_d = per_cnt_inc;
                valid_d  = 1'b1;
                if (per_cnt_inc == PER_MAX) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt_q <= '0;
            period_q  <= '0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign period_cycles   = period_q;
    assign period_valid    = valid_q;
    assign period_overflow = ovf_q;
endmodule

// File: tb/tb_breakbeam_multi_debounce.sv
// Scoreboard bench: expected strobes are queued when raw inputs are driven and
// matched against DUT strobes observed on the falling clock edge.
module tb_breakbeam_multi_debounce;
    typedef struct {
        int cyc;
        int kind;   // 0 rise, 1 fall, 2 period_valid
        int ch;
        int val;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // DUT A: defaults
    logic        rst_a;
    logic [1:0]  raw_a;
    logic [11:0] lim_a;
    logic [1:0]  clean_a, rise_a, fall_a;
    logic [23:0] per_a;
    logic        pvld_a, ovf_a;

    // DUT B: channel 1 inverted, 8-bit period counter
    logic        rst_b;
    logic [1:0]  raw_b;
    logic [11:0] lim_b;
    logic [1:0]  clean_b, rise_b, fall_b;
    logic [7:0]  per_b;
    logic        pvld_b, ovf_b;

    breakbeam_multi_debounce dut_a (
        .clk(clk), .reset(rst_a), .din_raw(raw_a), .debounce_limit(lim_a),
        .din_clean(clean_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
        .period_cycles(per_a), .period_valid(pvld_a), .period_overflow(ovf_a)
    );

    breakbeam_multi_debounce #(.INVERT_MASK(2'b10), .PERIOD_WIDTH(8)) dut_b (
        .clk(clk), .reset(rst_b), .din_raw(raw_b), .debounce_limit(lim_b),
        .din_clean(clean_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .period_cycles(per_b), .period_valid(pvld_b), .period_overflow(ovf_b)
    );

    ev_t sbq_a[$];
    ev_t qb[$];
    bit  armed_a = 1'b0;
    int  last_a  = 0;
    bit  armed_b = 1'b0;
    int  last_b  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queue an expected strobe on DUT A; a channel-0 rise also implies a period result.
    task automatic exp_a(input int ch, input int kind, input int at);
        ev_t e;
        e.cyc = at; e.kind = kind; e.ch = ch; e.val = 0;
        sbq_a.push_back(e);
        if (ch == 0 && kind == 0) begin
            if (armed_a) begin
                e.cyc = at + 1; e.kind = 2; e.val = at - last_a;
                sbq_a.push_back(e);
            end
            armed_a = 1'b1;
            last_a  = at;
        end
    endtask

    task automatic exp_b(input int at);
        ev_t e;
        if (armed_b) begin
            e.cyc = at + 1; e.kind = 2; e.ch = 0;
            e.val = (at - last_b > 255) ? 255 : at - last_b;
            qb.push_back(e);
        end
        armed_b = 1'b1;
        last_b  = at;
    endtask

    task automatic sb_take(input int kind, input int ch, input int val);
        int idx = -1;
        for (int i = 0; i < sbq_a.size(); i++)
            if (idx < 0 && sbq_a[i].kind == kind && sbq_a[i].ch == ch) idx = i;
        if (idx < 0) begin
            check($sformatf("unexpected_k%0d_ch%0d", kind, ch), cyc, -1);
        end else begin
            check($sformatf("evt_cyc_k%0d_ch%0d", kind, ch), cyc, sbq_a[idx].cyc);
            if (kind == 2) check("period_a_val", val, sbq_a[idx].val);
            sbq_a.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        for (int ch = 0; ch < 2; ch++) begin
            if (rise_a[ch] === 1'b1) sb_take(0, ch, 0);
            if (fall_a[ch] === 1'b1) sb_take(1, ch, 0);
        end
        if (pvld_a === 1'b1) sb_take(2, 0, int'(per_a));
        if (pvld_b === 1'b1) begin
            if (qb.size() == 0) begin
                check("unexpected_pvld_b", cyc, -1);
            end else begin
                e = qb.pop_front();
                check("pvld_b_cyc", cyc, e.cyc);
                check("period_b_val", per_b, e.val);
            end
        end
    end

    initial begin
        int t;
        int gap[4];
        gap[0] = 300; gap[1] = 300; gap[2] = 100; gap[3] = 40;

        rst_a = 1'b1; rst_b = 1'b1;
        raw_a = 2'b00; raw_b = 2'b00;
        lim_a = 12'd4; lim_b = 12'd4;
        wait_n(3);
        check("rst_clean_a", clean_a, 0);
        check("rst_rise_a", rise_a, 0);
        check("rst_fall_a", fall_a, 0);
        check("rst_period_a", per_a, 0);
        check("rst_pvld_a", pvld_a, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_clean_b", clean_b, 0);
        check("rst_period_b", per_b, 0);
        check("rst_ovf_b", ovf_b, 0);

        // Inverted channel with raw held low settles high after 2+4 edges
        rst_b = 1'b0;
        wait_n(5);
        check("inv_clean1_early", clean_b[1], 0);
        wait_n(1);
        check("inv_clean1", clean_b[1], 1);
        check("inv_rise1", rise_b[1], 1);
        wait_n(1);
        check("inv_rise1_single", rise_b[1], 0);

        rst_a = 1'b0;
        wait_n(1);

        // Basic rise on ch0 with limit 4
        raw_a[0] = 1'b1; exp_a(0, 0, cyc + 6);
        wait_n(10);
        check("clean0_high", clean_a[0], 1);

        // 3-cycle glitch on ch1 must be filtered
        raw_a[1] = 1'b1; wait_n(3); raw_a[1] = 1'b0;
        wait_n(10);
        check("glitch_clean1", clean_a[1], 0);

        raw_a[0] = 1'b0; exp_a(0, 1, cyc + 6);
        wait_n(10);

        // Both channels change together
        raw_a = 2'b11; exp_a(0, 0, cyc + 6); exp_a(1, 0, cyc + 6);
        wait_n(10);
        check("simul_clean_hi", clean_a, 3);
        raw_a = 2'b00; exp_a(0, 1, cyc + 6); exp_a(1, 1, cyc + 6);
        wait_n(10);
        check("simul_clean_lo", clean_a, 0);

        // Reset lands with ch0 two counts into a limit-4 debounce
        raw_a[0] = 1'b1; t = cyc;
        wait_n(4);
        rst_a = 1'b1; armed_a = 1'b0;
        wait_n(1);
        rst_a = 1'b0;
        check("rst_mid_clean0", clean_a[0], 0);
        check("rst_mid_rise0", rise_a[0], 0);
        exp_a(0, 0, t + 11);
        wait_n(14);

        // Limit lowered mid-count accepts on the next differing cycle
        lim_a = 12'd8; raw_a[1] = 1'b1; t = cyc;
        wait_n(6);
        lim_a = 12'd2; exp_a(1, 0, t + 7);
        wait_n(10);

        // Limit 0 behaves as 1
        lim_a = 12'd0; raw_a[1] = 1'b0; exp_a(1, 1, cyc + 3);
        wait_n(10);

        // Period measurement, 1000-cycle spacing, limit 1
        rst_a = 1'b1; armed_a = 1'b0; raw_a = 2'b00;
        wait_n(2);
        rst_a = 1'b0; lim_a = 12'd1;
        wait_n(2);
        for (int k = 0; k < 4; k++) begin
            raw_a[0] = 1'b1; exp_a(0, 0, cyc + 3);
            wait_n(10);
            raw_a[0] = 1'b0; exp_a(0, 1, cyc + 3);
            wait_n(990);
        end
        check("period_1000", per_a, 1000);
        check("ovf_a_clear", ovf_a, 0);

        // Saturation on the 8-bit instance
        for (int i = 0; i < 4; i++) begin
            if (i == 1) check("ovf_b_before", ovf_b, 0);
            raw_b[0] = 1'b1; exp_b(cyc + 6);
            wait_n(10);
            raw_b[0] = 1'b0;
            if (i == 1) begin
                check("ovf_b_set", ovf_b, 1);
                check("period_b_sat", per_b, 255);
            end
            wait_n(gap[i] - 10);
        end
        check("ovf_b_sticky", ovf_b, 1);
        check("period_b_100", per_b, 100);

        check("sbq_a_drained", sbq_a.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
